// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : picoMIPS instruction-flow controller that drives programCounter
//               with hold/inc/absolute/relative controls, MUL and WAITGO stalls
//               and HALT parking. Optional taken-branch counter is enabled by
//               defining PC_SEQ_BRANCH_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int P_SIZE     = 6,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        opClass,
  input  logic [P_SIZE-1:0] target,
  input  logic              zero,
  input  logic              go,
  output logic              inc,
  output logic              branchAbs,
  output logic              branchRel,
  output logic [P_SIZE-1:0] branchAddress,
  output logic              stall,
  output logic              halted,
  output logic [7:0]        branchCount
);

  localparam int CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
  localparam logic [CNT_W-1:0] C_MUL_LOAD = CNT_W'(MUL_CYCLES - 2);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_MULWAIT = 3'd2;
  localparam logic [2:0] S_GOWAIT  = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_JMP    = 3'd1;
  localparam logic [2:0] OP_BEQ    = 3'd2;
  localparam logic [2:0] OP_BNE    = 3'd3;
  localparam logic [2:0] OP_MUL    = 3'd4;
  localparam logic [2:0] OP_WAITGO = 3'd5;
  localparam logic [2:0] OP_HALT   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        case (opClass)
          OP_MUL: begin
            cnt_d   = C_MUL_LOAD;
            state_d = S_MULWAIT;
          end
          OP_WAITGO: if (!go) state_d = S_GOWAIT;
          OP_HALT:   state_d = S_HALT;
          default:   state_d = S_RUN;
        endcase
      end
      S_MULWAIT: begin
        if (cnt_q == '0) state_d = S_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_GOWAIT: if (go) state_d = S_RUN;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // RUN outputs are Mealy on the decoded instruction; wait states resolve on counter/go.
  always_comb begin
    inc       = 1'b0;
    branchAbs = 1'b0;
    branchRel = 1'b0;
    stall     = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_RUN: begin
        case (opClass)
          OP_JMP:    branchAbs = 1'b1;
          OP_BEQ:    if (zero) branchRel = 1'b1; else inc = 1'b1;
          OP_BNE:    if (!zero) branchRel = 1'b1; else inc = 1'b1;
          OP_MUL:    stall = 1'b1;
          OP_WAITGO: if (go) inc = 1'b1; else stall = 1'b1;
          OP_HALT:   inc = 1'b0;
          default:   inc = 1'b1;
        endcase
      end
      S_MULWAIT: if (cnt_q == '0) inc = 1'b1; else stall = 1'b1;
      S_GOWAIT:  if (go) inc = 1'b1; else stall = 1'b1;
      S_HALT:    halted = 1'b1;
      default:   inc = 1'b0;
    endcase
  end

  assign branchAddress = (branchAbs || branchRel) ? target : '0;

`ifdef PC_SEQ_BRANCH_COUNT_EN
  logic [7:0] bcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= 8'd0;
    end else if ((branchAbs || branchRel) && (bcnt_q != 8'hFF)) begin
      bcnt_q <= bcnt_q + 8'd1;
    end
  end

  assign branchCount = bcnt_q;
`else
  assign branchCount = 8'd0;
`endif

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-flow controller for the picoMIPS core. Sits between the instruction decoder and the `programCounter`. Each cycle it decides whether the PC holds, increments, branches absolutely or branches relatively. It also stalls the PC for multi-cycle multiplies and for external-input waits, and parks the core on HALT.

## Interface

Parameters:
- `P_SIZE`, default 6: PC / branch address width, matching `programCounter`.
- `MUL_CYCLES`, default 4: total cycles a MUL instruction occupies, ≥2.

Ports:
- `clk`: in, 1. Single clock, rising edge.
- `rst`: in, 1. Asynchronous, active-high reset.
- `start`: in, 1. Leaves IDLE and begins execution.
- `opClass`: in, 3. Decoded class of the current instruction:
  - 0 ALU/NOP
  - 1 JMP
  - 2 BEQ
  - 3 BNE
  - 4 MUL
  - 5 WAITGO
  - 6 HALT
  - 7 reserved, executes as NOP
- `target`: in, P_SIZE. Absolute target (JMP) or two's-complement offset (BEQ/BNE) from the instruction.
- `zero`: in, 1. ALU zero flag for the current instruction.
- `go`: in, 1. External release for WAITGO.
- `inc`: out, 1. To `programCounter.inc`.
- `branchAbs`: out, 1. To `programCounter.branchAbs`.
- `branchRel`: out, 1. To `programCounter.branchRel`.
- `branchAddress`: out, P_SIZE. To `programCounter.branchAddress`.
- `stall`: out, 1. High while a MUL or WAITGO is holding the PC.
- `halted`: out, 1. High in HALT state.
- `branchCount`: out, 8. Taken-branch counter; see Configuration.

## Operation

States: IDLE, RUN, MULWAIT, GOWAIT, HALT.
- IDLE: all control outputs 0. `start`=1 moves to RUN next edge.
- RUN: outputs decoded combinationally (Mealy) from `opClass` and `zero`.
  - ALU/NOP/reserved: `inc`=1.
  - JMP: `branchAbs`=1.
  - BEQ: `branchRel`=1 if `zero`=1, else `inc`=1.
  - BNE: `branchRel`=1 if `zero`=0, else `inc`=1.
  - MUL: all 0, `stall`=1. Loads cycle counter with MUL_CYCLES-2, goes to MULWAIT.
  - WAITGO with `go`=1: `inc`=1, stays in RUN.
  - WAITGO with `go`=0: `stall`=1, goes to GOWAIT.
  - HALT: all 0, goes to HALT.
- MULWAIT: `stall`=1.
  - Counter decrements each cycle.
  - On the cycle the counter reads 0: `inc`=1, `stall`=0, return to RUN.
- GOWAIT: `stall`=1 until `go`=1. In that cycle: `inc`=1, `stall`=0, return to RUN.
- HALT: all PC controls 0, `halted`=1. Only `rst` leaves it; `start` is ignored.
- Mutual exclusion: at most one of `inc`, `branchAbs`, `branchRel` is high in any cycle. The bench asserts this every cycle.
- `branchAddress` = `target` whenever `branchAbs` or `branchRel` is high, else 0.
- Relative arithmetic is done by the PC, modulo 2^P_SIZE. Offset 8 from 62 (P_SIZE=6) gives 6.

## Timing

- Controls are combinational from state and inputs. The PC updates at the next rising edge, so each instruction has one-cycle latency to the new address.
- A MUL occupies exactly MUL_CYCLES cycles from first decode to the cycle `inc` is asserted.
- `opClass`, `target` and `zero` must be held stable by the decoder while `stall`=1. The PC is frozen, so the instruction does not change.
- Reset values: state IDLE, cycle counter 0, `branchCount` 0, and all outputs 0.
- `rst` during MULWAIT or GOWAIT aborts immediately to IDLE; no `inc` is issued.
- `start` asserted while already in RUN/MULWAIT/GOWAIT has no effect.

## Configuration

- `PC_SEQ_BRANCH_COUNT_EN` defined:
  - `branchCount` increments on every cycle where `branchAbs` or `branchRel` is 1.
  - It saturates at 255 and clears only on `rst`.
- Not defined: no counter register is built and `branchCount` is tied to 0.

## Test plan

- Reset then `start`, `opClass`=0 for 3 cycles: `inc`=1 each cycle, PC reads 0→1→2→3, other controls 0.
- JMP `target`=5: `branchAbs`=1 and `branchAddress`=5 in one cycle, PC=5 next edge. Then BEQ `zero`=1 `target`=8: `branchRel`=1, PC=13. With `PC_SEQ_BRANCH_COUNT_EN` defined, `branchCount`=2.
- BEQ with `zero`=0, and BNE with `zero`=1: `inc`=1 and `branchRel`=0 in both cases, PC advances by 1.
- MUL with MUL_CYCLES=4 at PC=3: `stall`=1 and PC holds 3 for cycles 1–3, `inc`=1 in cycle 4, PC=4 after. Repeat with `rst` pulsed in cycle 2: state IDLE, all outputs 0, PC=0.
- WAITGO with `go`=0 for 5 cycles, then `go`=1: PC held and `stall`=1 throughout. `inc`=1 only in the `go` cycle.
- HALT: `halted`=1, all controls 0 for 10 cycles despite `start`=1. `rst` returns to IDLE with `halted`=0.
